// File: rtl/ysyx_24080006_pkg.sv
// Shared AXI4 channel structs and arbiter enums for the ysyx_24080006 core.
package ysyx_24080006_pkg;

    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [3:0]  arid;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic [3:0]  rid;
    } axi_r_s2m_t;

    typedef struct packed {
        logic        awvalid;
        logic [31:0] awaddr;
        logic [3:0]  awid;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
    } axi_w_m2s_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic        bvalid;
        logic [1:0]  bresp;
        logic [3:0]  bid;
    } axi_w_s2m_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IFU_AR = 3'd1,
        IFU_R  = 3'd2,
        LSU_AR = 3'd3,
        LSU_R  = 3'd4
    } arb_state_e;

    typedef enum logic {
        GRANT_IFU = 1'b0,
        GRANT_LSU = 1'b1
    } arb_grant_e;

    function automatic arb_state_e ar_state_of(input arb_grant_e g);
        return (g == GRANT_LSU) ? LSU_AR : IFU_AR;
    endfunction

endpackage

// File: rtl/ysyx_24080006_axi_arbiter.sv
// IFU/LSU to memory AXI4 read arbiter; whole transactions are serialised.
// Define YSYX_24080006_ARB_RR_EN for round-robin ties, otherwise LSU wins ties.
module ysyx_24080006_axi_arbiter
    import ysyx_24080006_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  axi_r_m2s_t ifu_r_m2s,
    output axi_r_s2m_t ifu_r_s2m,
    input  axi_r_m2s_t lsu_r_m2s,
    output axi_r_s2m_t lsu_r_s2m,
    input  axi_w_m2s_t lsu_w_m2s,
    output axi_w_s2m_t lsu_w_s2m,
    output axi_r_m2s_t mem_r_m2s,
    input  axi_r_s2m_t mem_r_s2m,
    output axi_w_m2s_t mem_w_m2s,
    input  axi_w_s2m_t mem_w_s2m,
    output arb_state_e state
);

    arb_state_e state_q;
    arb_state_e state_d;
    arb_grant_e pick;
    logic       ifu_req;
    logic       lsu_req;

    assign ifu_req = ifu_r_m2s.arvalid;
    assign lsu_req = lsu_r_m2s.arvalid;

`ifdef YSYX_24080006_ARB_RR_EN
    arb_grant_e last_grant_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= GRANT_IFU;
        end else if (state_q == IDLE && (ifu_req || lsu_req)) begin
            last_grant_q <= pick;
        end
    end

    // On a tie, the master that did not win last time goes first.
    always_comb begin
        if (ifu_req && lsu_req) begin
            pick = (last_grant_q == GRANT_IFU) ? GRANT_LSU : GRANT_IFU;
        end else begin
            pick = lsu_req ? GRANT_LSU : GRANT_IFU;
        end
    end
`else
    assign pick = lsu_req ? GRANT_LSU : GRANT_IFU;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ifu_req || lsu_req) begin
                    state_d = ar_state_of(pick);
                end
            end
            IFU_AR: begin
                if (ifu_r_m2s.arvalid && mem_r_s2m.arready) begin
                    state_d = IFU_R;
                end
            end
            IFU_R: begin
                if (mem_r_s2m.rvalid && ifu_r_m2s.rready && mem_r_s2m.rlast) begin
                    state_d = IDLE;
                end
            end
            LSU_AR: begin
                if (lsu_r_m2s.arvalid && mem_r_s2m.arready) begin
                    state_d = LSU_R;
                end
            end
            LSU_R: begin
                if (mem_r_s2m.rvalid && lsu_r_m2s.rready && mem_r_s2m.rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // AR fields are not latched: masters hold them stable until arready.
    always_comb begin
        mem_r_m2s = '0;
        ifu_r_s2m = '0;
        lsu_r_s2m = '0;
        case (state_q)
            IFU_AR: begin
                mem_r_m2s         = ifu_r_m2s;
                mem_r_m2s.rready  = 1'b0;
                ifu_r_s2m.arready = mem_r_s2m.arready;
            end
            IFU_R: begin
                mem_r_m2s.rready  = ifu_r_m2s.rready;
                ifu_r_s2m         = mem_r_s2m;
                ifu_r_s2m.arready = 1'b0;
            end
            LSU_AR: begin
                mem_r_m2s         = lsu_r_m2s;
                mem_r_m2s.rready  = 1'b0;
                lsu_r_s2m.arready = mem_r_s2m.arready;
            end
            LSU_R: begin
                mem_r_m2s.rready  = lsu_r_m2s.rready;
                lsu_r_s2m         = mem_r_s2m;
                lsu_r_s2m.arready = 1'b0;
            end
            default: ;
        endcase
    end

    assign mem_w_m2s = lsu_w_m2s;
    assign lsu_w_s2m = mem_w_s2m;
    assign state     = state_q;

endmodule
